// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates score/paddle/wall requests and plays each
// granted effect as a fixed note list paced by beat_tick, driving the tone generator.
module sfx_scheduler #(
  parameter logic [31:0] SILENT_FREQ  = 32'd20000,
  parameter bit          PRIO_PREEMPT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        beat_tick,
  input  logic [2:0]  req,
  input  logic        mute,
  output logic [31:0] tone_freq,
  output logic        tone_en,
  output logic        busy,
  output logic [2:0]  grant,
  output logic        done
);

  localparam int unsigned FREQ_W = 32;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned EFF_W  = 3;

  localparam logic [EFF_W-1:0] EFF_WALL   = 3'b001;
  localparam logic [EFF_W-1:0] EFF_PADDLE = 3'b010;
  localparam logic [EFF_W-1:0] EFF_SCORE  = 3'b100;

  typedef enum logic {ST_IDLE, ST_PLAY} state_t;

  state_t             r_state, w_state_nxt;
  logic [EFF_W-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [LEN_W-1:0]   r_remain, w_remain_nxt;
  logic [EFF_W-1:0]   r_pending, w_pending_nxt;
  logic [FREQ_W-1:0]  r_freq, w_freq_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic [EFF_W-1:0]   w_req_eff;
  logic [EFF_W-1:0]   w_cand;
  logic [EFF_W-1:0]   w_top;
  logic [EFF_W-1:0]   w_grant_new;
  logic               w_preempt;

  // Fixed note table: frequency in Hz per effect and note index.
  function automatic logic [FREQ_W-1:0] note_freq(input logic [EFF_W-1:0] eff,
                                                  input logic [IDX_W-1:0] idx);
    logic [FREQ_W-1:0] f;
    f = SILENT_FREQ;
    case (eff)
      EFF_WALL:   f = 32'd392;
      EFF_PADDLE: f = (idx == 2'd0) ? 32'd523 : 32'd784;
      EFF_SCORE: begin
        case (idx)
          2'd0:    f = 32'd262;
          2'd1:    f = 32'd330;
          2'd2:    f = 32'd392;
          default: f = 32'd523;
        endcase
      end
      default:    f = SILENT_FREQ;
    endcase
    return f;
  endfunction

  function automatic logic [LEN_W-1:0] note_len(input logic [EFF_W-1:0] eff,
                                                input logic [IDX_W-1:0] idx);
    logic [LEN_W-1:0] l;
    l = 3'd1;
    if (eff == EFF_SCORE) l = (idx == 2'd3) ? 3'd4 : 3'd2;
    return l;
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input logic [EFF_W-1:0] eff);
    logic [IDX_W-1:0] n;
    n = 2'd0;
    case (eff)
      EFF_PADDLE: n = 2'd1;
      EFF_SCORE:  n = 2'd3;
      default:    n = 2'd0;
    endcase
    return n;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_remain  <= '0;
      r_pending <= '0;
      r_freq    <= SILENT_FREQ;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_remain  <= w_remain_nxt;
      r_pending <= w_pending_nxt;
      r_freq    <= w_freq_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Requests of the effect already playing are dropped, never queued.
  always_comb begin
    w_req_eff = req & ~r_grant;
    w_cand    = r_pending | w_req_eff;
    w_top     = '0;
    if (w_cand[2])      w_top = EFF_SCORE;
    else if (w_cand[1]) w_top = EFF_PADDLE;
    else if (w_cand[0]) w_top = EFF_WALL;
    w_preempt = PRIO_PREEMPT && (r_state == ST_PLAY) && (w_top > r_grant);
  end

  // Next-state logic; a new grant overrides any beat_tick on the same edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_idx_nxt    = r_idx;
    w_remain_nxt = r_remain;
    w_freq_nxt   = r_freq;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_grant_new  = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_cand != '0) w_grant_new = w_top;
      end
      ST_PLAY: begin
        if (w_preempt) begin
          w_grant_new = w_top;
        end else if (beat_tick) begin
          if (r_remain > 3'd1) begin
            w_remain_nxt = r_remain - 3'd1;
          end else if (r_idx != last_idx(r_grant)) begin
            w_idx_nxt    = r_idx + 2'd1;
            w_remain_nxt = note_len(r_grant, r_idx + 2'd1);
            w_freq_nxt   = note_freq(r_grant, r_idx + 2'd1);
          end else begin
            w_state_nxt  = ST_IDLE;
            w_grant_nxt  = '0;
            w_idx_nxt    = '0;
            w_remain_nxt = '0;
            w_freq_nxt   = SILENT_FREQ;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_grant_new != '0) begin
      w_state_nxt  = ST_PLAY;
      w_grant_nxt  = w_grant_new;
      w_idx_nxt    = '0;
      w_remain_nxt = note_len(w_grant_new, 2'd0);
      w_freq_nxt   = note_freq(w_grant_new, 2'd0);
      w_busy_nxt   = 1'b1;
    end

    w_pending_nxt = (r_pending | w_req_eff) & ~w_grant_new;
  end

  // Outputs: mute only masks the audible tone, never the sequencing.
  always_comb begin
    tone_freq = mute ? SILENT_FREQ : r_freq;
    tone_en   = r_busy & ~mute;
    busy      = r_busy;
    grant     = r_grant;
    done      = r_done;
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: per-scenario step tables feed an expected-value
// queue that is popped and compared after each clock.
module tb_sfx_scheduler;

  logic        clk;
  logic        reset;
  logic        beat_tick;
  logic [2:0]  req;
  logic        mute;
  logic [31:0] tone_freq;
  logic        tone_en;
  logic        busy;
  logic [2:0]  grant;
  logic        done;

  int total;
  int bad;

  typedef struct packed {
    logic [2:0]  g;
    logic        b;
    logic        d;
    logic        e;
    logic [31:0] f;
  } obs_t;

  typedef struct packed {
    logic [2:0] r;
    logic       t;
    logic       m;
    obs_t       x;
  } step_t;

  obs_t sb[$];

  sfx_scheduler #(.SILENT_FREQ(32'd20000), .PRIO_PREEMPT(1'b1)) dut (
    .clk(clk), .reset(reset), .beat_tick(beat_tick), .req(req), .mute(mute),
    .tone_freq(tone_freq), .tone_en(tone_en), .busy(busy), .grant(grant), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic obs_t ob(input logic [2:0] g, input logic b, input logic d,
                              input logic e, input int f);
    obs_t o;
    o.g = g; o.b = b; o.d = d; o.e = e; o.f = 32'(f);
    return o;
  endfunction

  function automatic step_t st(input logic [2:0] r, input logic t, input logic m, input obs_t x);
    step_t s;
    s.r = r; s.t = t; s.m = m; s.x = x;
    return s;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.g = grant; o.b = busy; o.d = done; o.e = tone_en; o.f = tone_freq;
    return o;
  endfunction

  task automatic drive(input step_t s);
    req = s.r; beat_tick = s.t; mute = s.m;
    @(posedge clk); #1;
    req = 3'b000; beat_tick = 1'b0;
  endtask

  task automatic test_reset();
    obs_t a, x;
    reset = 1'b0; req = 3'b000; beat_tick = 1'b0; mute = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(ob(3'b000, 0, 0, 0, 20000));
    a = cur(); x = sb.pop_front(); total++;
    if (a !== x) begin
      bad++;
      $display("FAIL reset: got g=%b b=%b d=%b e=%b f=%0d exp g=%b b=%b d=%b e=%b f=%0d",
               a.g, a.b, a.d, a.e, a.f, x.g, x.b, x.d, x.e, x.f);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    sb.push_back(ob(3'b000, 0, 0, 0, 20000));
    a = cur(); x = sb.pop_front(); total++;
    if (a !== x) begin
      bad++;
      $display("FAIL reset_release: got g=%b f=%0d exp g=%b f=%0d", a.g, a.f, x.g, x.f);
    end
  endtask

  task automatic test_wall();
    step_t s[$];
    s.push_back(st(3'b001, 0, 0, ob(3'b001, 1, 0, 1, 392)));
    s.push_back(st(3'b000, 1, 0, ob(3'b000, 0, 1, 0, 20000)));
    s.push_back(st(3'b000, 0, 0, ob(3'b000, 0, 0, 0, 20000)));
    foreach (s[i]) begin
      obs_t a, x;
      sb.push_back(s[i].x); drive(s[i]); a = cur(); x = sb.pop_front(); total++;
      if (a !== x) begin
        bad++;
        $display("FAIL wall[%0d]: got g=%b b=%b d=%b e=%b f=%0d exp g=%b b=%b d=%b e=%b f=%0d",
                 i, a.g, a.b, a.d, a.e, a.f, x.g, x.b, x.d, x.e, x.f);
      end
    end
  endtask

  task automatic test_paddle();
    step_t s[$];
    s.push_back(st(3'b010, 0, 0, ob(3'b010, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b010, 1, 0, 1, 784)));
    s.push_back(st(3'b000, 0, 0, ob(3'b010, 1, 0, 1, 784)));
    s.push_back(st(3'b000, 1, 0, ob(3'b000, 0, 1, 0, 20000)));
    s.push_back(st(3'b000, 0, 0, ob(3'b000, 0, 0, 0, 20000)));
    foreach (s[i]) begin
      obs_t a, x;
      sb.push_back(s[i].x); drive(s[i]); a = cur(); x = sb.pop_front(); total++;
      if (a !== x) begin
        bad++;
        $display("FAIL paddle[%0d]: got g=%b b=%b d=%b e=%b f=%0d exp g=%b b=%b d=%b e=%b f=%0d",
                 i, a.g, a.b, a.d, a.e, a.f, x.g, x.b, x.d, x.e, x.f);
      end
    end
  endtask

  task automatic test_preempt();
    step_t s[$];
    s.push_back(st(3'b010, 0, 0, ob(3'b010, 1, 0, 1, 523)));
    s.push_back(st(3'b100, 0, 0, ob(3'b100, 1, 0, 1, 262)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 262)));
    s.push_back(st(3'b000, 0, 0, ob(3'b100, 1, 0, 1, 262)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 330)));
    s.push_back(st(3'b100, 0, 0, ob(3'b100, 1, 0, 1, 330)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 330)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 392)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 392)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b000, 0, 1, 0, 20000)));
    s.push_back(st(3'b000, 0, 0, ob(3'b000, 0, 0, 0, 20000)));
    s.push_back(st(3'b000, 0, 0, ob(3'b000, 0, 0, 0, 20000)));
    foreach (s[i]) begin
      obs_t a, x;
      sb.push_back(s[i].x); drive(s[i]); a = cur(); x = sb.pop_front(); total++;
      if (a !== x) begin
        bad++;
        $display("FAIL preempt[%0d]: got g=%b b=%b d=%b e=%b f=%0d exp g=%b b=%b d=%b e=%b f=%0d",
                 i, a.g, a.b, a.d, a.e, a.f, x.g, x.b, x.d, x.e, x.f);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    s.push_back(st(3'b011, 0, 0, ob(3'b010, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b010, 1, 0, 1, 784)));
    s.push_back(st(3'b000, 1, 0, ob(3'b000, 0, 1, 0, 20000)));
    s.push_back(st(3'b000, 0, 0, ob(3'b001, 1, 0, 1, 392)));
    s.push_back(st(3'b000, 1, 0, ob(3'b000, 0, 1, 0, 20000)));
    s.push_back(st(3'b000, 0, 0, ob(3'b000, 0, 0, 0, 20000)));
    s.push_back(st(3'b001, 1, 0, ob(3'b001, 1, 0, 1, 392)));
    s.push_back(st(3'b000, 1, 0, ob(3'b000, 0, 1, 0, 20000)));
    s.push_back(st(3'b000, 0, 0, ob(3'b000, 0, 0, 0, 20000)));
    foreach (s[i]) begin
      obs_t a, x;
      sb.push_back(s[i].x); drive(s[i]); a = cur(); x = sb.pop_front(); total++;
      if (a !== x) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got g=%b b=%b d=%b e=%b f=%0d exp g=%b b=%b d=%b e=%b f=%0d",
                 i, a.g, a.b, a.d, a.e, a.f, x.g, x.b, x.d, x.e, x.f);
      end
    end
  endtask

  task automatic test_mute();
    step_t s[$];
    s.push_back(st(3'b100, 0, 0, ob(3'b100, 1, 0, 1, 262)));
    s.push_back(st(3'b000, 0, 1, ob(3'b100, 1, 0, 0, 20000)));
    s.push_back(st(3'b000, 1, 1, ob(3'b100, 1, 0, 0, 20000)));
    s.push_back(st(3'b000, 1, 1, ob(3'b100, 1, 0, 0, 20000)));
    s.push_back(st(3'b000, 1, 1, ob(3'b100, 1, 0, 0, 20000)));
    s.push_back(st(3'b000, 1, 1, ob(3'b100, 1, 0, 0, 20000)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 392)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 523)));
    s.push_back(st(3'b000, 1, 0, ob(3'b000, 0, 1, 0, 20000)));
    s.push_back(st(3'b000, 0, 0, ob(3'b000, 0, 0, 0, 20000)));
    foreach (s[i]) begin
      obs_t a, x;
      sb.push_back(s[i].x); drive(s[i]); a = cur(); x = sb.pop_front(); total++;
      if (a !== x) begin
        bad++;
        $display("FAIL mute[%0d]: got g=%b b=%b d=%b e=%b f=%0d exp g=%b b=%b d=%b e=%b f=%0d",
                 i, a.g, a.b, a.d, a.e, a.f, x.g, x.b, x.d, x.e, x.f);
      end
    end
  endtask

  task automatic test_mid_reset();
    step_t s[$];
    obs_t  a, x;
    s.push_back(st(3'b100, 0, 0, ob(3'b100, 1, 0, 1, 262)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 262)));
    s.push_back(st(3'b000, 1, 0, ob(3'b100, 1, 0, 1, 330)));
    s.push_back(st(3'b001, 0, 0, ob(3'b100, 1, 0, 1, 330)));
    foreach (s[i]) begin
      sb.push_back(s[i].x); drive(s[i]); a = cur(); x = sb.pop_front(); total++;
      if (a !== x) begin
        bad++;
        $display("FAIL mid_reset_pre[%0d]: got g=%b b=%b d=%b e=%b f=%0d exp g=%b b=%b d=%b e=%b f=%0d",
                 i, a.g, a.b, a.d, a.e, a.f, x.g, x.b, x.d, x.e, x.f);
      end
    end
    // Asynchronous: outputs must clear well before the next clock edge.
    reset = 1'b0;
    #2;
    sb.push_back(ob(3'b000, 0, 0, 0, 20000));
    a = cur(); x = sb.pop_front(); total++;
    if (a !== x) begin
      bad++;
      $display("FAIL mid_reset_async: got g=%b b=%b d=%b e=%b f=%0d exp g=%b b=%b d=%b e=%b f=%0d",
               a.g, a.b, a.d, a.e, a.f, x.g, x.b, x.d, x.e, x.f);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(ob(3'b000, 0, 0, 0, 20000));
      @(posedge clk); #1;
      a = cur(); x = sb.pop_front(); total++;
      if (a !== x) begin
        bad++;
        $display("FAIL mid_reset_no_replay[%0d]: got g=%b b=%b f=%0d exp g=%b b=%b f=%0d",
                 k, a.g, a.b, a.f, x.g, x.b, x.f);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    req   = 3'b000;
    beat_tick = 1'b0;
    mute  = 1'b0;
    test_reset();
    test_wall();
    test_paddle();
    test_preempt();
    test_back_to_back();
    test_mute();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
